alu32_arb_ctrl: RTL and testbench

ALU32_ARB_CTRL -- requirements
Module: alu32_arb_ctrl

---
 rtl/alu32_arb_ctrl_if.sv | 40 ++++
 rtl/alu32_arb_ctrl.sv | 94 +++++++++
 tb/tb_alu32_arb_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu32_arb_ctrl_if.sv
// rtl/alu32_arb_ctrl_if.sv - requester, shared-ALU and completion signals of alu32_arb_ctrl
//
// Purpose: bundles the two requester ports, the shared alu32 drive/return
// pair and the completion outputs into one interface.
// Ports (slave = the controller, master = requesters plus the ALU):
//   req0/req1, op0/op1, a0/a1, b0/b1   requester operation requests and operands
//   gnt                                one-hot grant pulse
//   alu_op, alu_a, alu_b               operands driven to the shared alu32
//   alu_result, alu_flags              alu32 result and {c,n,z,v}
//   done, done_id, result, flags       completion pulse, winner index, registered result/flags
interface alu32_arb_ctrl_if;
    logic        req0;
    logic        req1;
    logic [2:0]  op0;
    logic [2:0]  op1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] b0;
    logic [31:0] b1;
    logic [1:0]  gnt;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        done;
    logic        done_id;
    logic [31:0] result;
    logic [3:0]  flags;

    modport slave (
        input  req0, req1, op0, op1, a0, a1, b0, b1, alu_result, alu_flags,
        output gnt, alu_op, alu_a, alu_b, done, done_id, result, flags
    );

    modport master (
        output req0, req1, op0, op1, a0, a1, b0, b1, alu_result, alu_flags,
        input  gnt, alu_op, alu_a, alu_b, done, done_id, result, flags
    );
endinterface

// File: rtl/alu32_arb_ctrl.sv
// rtl/alu32_arb_ctrl.sv - two-requester round-robin arbiter sharing one alu32
//
// Purpose: grants one of two requesters, holds its operands on the shared
// alu32 for EXEC_CYCLES cycles, captures the result/flags in the last of
// those cycles and reports completion with a one-cycle done pulse.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    alu32_arb_ctrl_if.slave (requests, ALU drive/return, completion)
// Parameter:
//   EXEC_CYCLES  cycles the operands are held on the ALU before capture (1..15)
module alu32_arb_ctrl #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    alu32_arb_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       last_id;
    logic       win_id;
    logic       pick;

    // On a tie the requester that did not win last time gets the ALU;
    // otherwise whichever one is asking (req1 alone selects 1).
    assign pick = (bus.req0 && bus.req1) ? ~last_id : bus.req1;

    // The alu_op/alu_a/alu_b registers double as the operand registers:
    // loaded at grant, held through EXEC, cleared once the result is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            last_id     <= 1'b1;
            win_id      <= 1'b0;
            bus.gnt     <= 2'b00;
            bus.alu_op  <= 3'd0;
            bus.alu_a   <= 32'd0;
            bus.alu_b   <= 32'd0;
            bus.done    <= 1'b0;
            bus.done_id <= 1'b0;
            bus.result  <= 32'd0;
            bus.flags   <= 4'd0;
        end else begin
            bus.gnt  <= 2'b00;
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        win_id     <= pick;
                        last_id    <= pick;
                        bus.gnt    <= pick ? 2'b10 : 2'b01;
                        bus.alu_op <= pick ? bus.op1 : bus.op0;
                        bus.alu_a  <= pick ? bus.a1  : bus.a0;
                        bus.alu_b  <= pick ? bus.b1  : bus.b0;
                        cnt        <= 4'd0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    cnt <= cnt + 4'd1;
                    // Only the final EXEC cycle's ALU output is trusted.
                    if (cnt == LAST_CNT) begin
                        bus.result <= bus.alu_result;
                        bus.flags  <= bus.alu_flags;
                        bus.alu_op <= 3'd0;
                        bus.alu_a  <= 32'd0;
                        bus.alu_b  <= 32'd0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    // done is registered, so it is visible in the cycle after
                    // DONE, alongside the following IDLE cycle.
                    bus.done    <= 1'b1;
                    bus.done_id <= win_id;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu32_arb_ctrl.sv
// tb/tb_alu32_arb_ctrl.sv - scoreboard bench for alu32_arb_ctrl
module tb_alu32_arb_ctrl;

    localparam int E1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1;
    logic rst3;
    logic rst4;

    alu32_arb_ctrl_if if1 ();
    alu32_arb_ctrl_if if3 ();
    alu32_arb_ctrl_if if4 ();

    alu32_arb_ctrl #(.EXEC_CYCLES(1)) u1 (.clk(clk), .reset(rst1), .bus(if1.slave));
    alu32_arb_ctrl #(.EXEC_CYCLES(3)) u3 (.clk(clk), .reset(rst3), .bus(if3.slave));
    alu32_arb_ctrl #(.EXEC_CYCLES(4)) u4 (.clk(clk), .reset(rst4), .bus(if4.slave));

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference alu32: returns {c,n,z,v,result}.
    function automatic logic [35:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        c;
        logic        v;
        c = 1'b0;
        v = 1'b0;
        w = 33'd0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[31:0];
                c = w[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd4: r = a << b[4:0];
            3'd5: r = a >> b[4:0];
            3'd6: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            default: r = b;
        endcase
        return {c, r[31], (r == 32'd0), v, r};
    endfunction

    always_comb {if1.alu_flags, if1.alu_result} = alu_fn(if1.alu_op, if1.alu_a, if1.alu_b);

    typedef struct {
        int   cyc;
        logic id;
    } gexp_t;

    typedef struct {
        int          cyc;
        logic        id;
        logic [31:0] res;
        logic [3:0]  fl;
    } dexp_t;

    gexp_t gq[$];
    dexp_t dq[$];

    // Requester-side model state: pending operations and arbitration timeline.
    bit          pend[2];
    logic [2:0]  p_op[2];
    logic [31:0] p_a[2];
    logic [31:0] p_b[2];
    int          avail;
    logic        last;

    // Called once per cycle just after a clock edge: creates new requests,
    // drives the requester ports, and predicts what the next edge does.
    task automatic step(input int prob);
        logic        w;
        logic [35:0] r;
        for (int i = 0; i < 2; i++) begin
            if (!pend[i] && $urandom_range(99) < prob) begin
                pend[i] = 1'b1;
                p_op[i] = 3'($urandom);
                p_a[i]  = $urandom;
                p_b[i]  = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom;
            end
        end
        if1.req0 = pend[0];
        if1.req1 = pend[1];
        if1.op0  = pend[0] ? p_op[0] : 3'($urandom);
        if1.a0   = pend[0] ? p_a[0]  : $urandom;
        if1.b0   = pend[0] ? p_b[0]  : $urandom;
        if1.op1  = pend[1] ? p_op[1] : 3'($urandom);
        if1.a1   = pend[1] ? p_a[1]  : $urandom;
        if1.b1   = pend[1] ? p_b[1]  : $urandom;
        if ((pend[0] || pend[1]) && (cyc + 1 >= avail)) begin
            w = (pend[0] && pend[1]) ? !last : pend[1];
            r = alu_fn(p_op[w], p_a[w], p_b[w]);
            gq.push_back('{cyc + 1, w});
            dq.push_back('{cyc + 1 + E1 + 1, w, r[31:0], r[35:32]});
            avail   = cyc + 1 + E1 + 2;
            last    = w;
            pend[w] = 1'b0;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_u1;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        if1.req0 = 1'b0;
        if1.req1 = 1'b0;
        rst1 = 1'b1;
        tick();
        tick();
        rst1  = 1'b0;
        last  = 1'b1;
        avail = cyc + 1;
    endtask

    // Monitor for u1: compares every grant and completion against the queues.
    initial begin
        gexp_t g;
        dexp_t d;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                while (gq.size() > 0 && gq[0].cyc < cyc) begin
                    g = gq.pop_front();
                    chk("gnt_missing_cycle", 64'(cyc), 64'(g.cyc));
                end
                if (gq.size() > 0 && gq[0].cyc == cyc) begin
                    g = gq.pop_front();
                    chk("gnt", 64'(if1.gnt), g.id ? 64'd2 : 64'd1);
                end else if (if1.gnt != 2'b00) begin
                    chk("gnt_unexpected", 64'(if1.gnt), 64'd0);
                end
                while (dq.size() > 0 && dq[0].cyc < cyc) begin
                    d = dq.pop_front();
                    chk("done_missing_cycle", 64'(cyc), 64'(d.cyc));
                end
                if (dq.size() > 0 && dq[0].cyc == cyc) begin
                    d = dq.pop_front();
                    chk("done", 64'(if1.done), 64'd1);
                    chk("done_id", 64'(if1.done_id), 64'(d.id));
                    chk("result", 64'(if1.result), 64'(d.res));
                    chk("flags", 64'(if1.flags), 64'(d.fl));
                end else if (if1.done) begin
                    chk("done_unexpected", 64'(if1.done), 64'd0);
                end
            end
        end
    end

    initial begin
        int d4;
        rst1 = 1'b1;
        rst3 = 1'b1;
        rst4 = 1'b1;
        {if1.req0, if1.req1, if1.op0, if1.op1} = '0;
        {if1.a0, if1.a1, if1.b0, if1.b1} = '0;
        {if3.req0, if3.req1, if3.op0, if3.op1, if3.a0, if3.a1, if3.b0, if3.b1} = '0;
        {if3.alu_result, if3.alu_flags} = '0;
        {if4.req0, if4.req1, if4.op0, if4.op1, if4.a0, if4.a1, if4.b0, if4.b1} = '0;
        {if4.alu_result, if4.alu_flags} = '0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        last    = 1'b1;
        avail   = 0;
        repeat (3) tick();

        chk("rst_gnt", 64'(if1.gnt), 64'd0);
        chk("rst_done", 64'(if1.done), 64'd0);
        chk("rst_done_id", 64'(if1.done_id), 64'd0);
        chk("rst_result", 64'(if1.result), 64'd0);
        chk("rst_flags", 64'(if1.flags), 64'd0);
        chk("rst_alu_a", 64'(if1.alu_a), 64'd0);
        chk("rst_alu_op", 64'(if1.alu_op), 64'd0);

        rst1   = 1'b0;
        avail  = cyc + 1;
        mon_en = 1'b1;

        // Single op: 7FFFFFFF + 1 -> 80000000, flags 0101.
        pend[0] = 1'b1;
        p_op[0] = 3'b110;
        p_a[0]  = 32'h7FFF_FFFF;
        p_b[0]  = 32'd1;
        repeat (6) begin
            step(0);
            tick();
        end

        // Tie straight after reset: requester 0 first, then 1.
        reset_u1();
        pend[0] = 1'b1;
        pend[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            p_op[i] = 3'(i + 1);
            p_a[i]  = $urandom;
            p_b[i]  = $urandom;
        end
        repeat (10) begin
            step(0);
            tick();
        end

        // Sustained contention: both re-request continuously.
        repeat (20) begin
            step(100);
            tick();
        end
        repeat (8) begin
            step(0);
            tick();
        end

        // Random traffic, then drain.
        repeat (400) begin
            step(35);
            tick();
        end
        repeat (10) begin
            step(0);
            tick();
        end
        chk("gq_drained", 64'(gq.size()), 64'd0);
        chk("dq_drained", 64'(dq.size()), 64'd0);
        mon_en = 1'b0;

        // EXEC_CYCLES=3: only the 3rd EXEC cycle's ALU output is captured.
        rst3 = 1'b0;
        tick();
        if3.req0 = 1'b1;
        if3.op0  = 3'd2;
        if3.a0   = 32'h1234_5678;
        if3.b0   = 32'h0000_00A5;
        if3.alu_result = 32'hEEEE_EEEE;
        if3.alu_flags  = 4'hE;
        tick();
        chk("c3_gnt", 64'(if3.gnt), 64'd1);
        if3.req0 = 1'b0;
        if3.a0   = 32'hFFFF_0000;
        if3.b0   = 32'h0BAD_0BAD;
        for (int k = 1; k <= 3; k++) begin
            if3.alu_result = 32'(k);
            if3.alu_flags  = 4'(k);
            chk("c3_alu_a", 64'(if3.alu_a), 64'h1234_5678);
            chk("c3_alu_b", 64'(if3.alu_b), 64'h0000_00A5);
            chk("c3_alu_op", 64'(if3.alu_op), 64'd2);
            chk("c3_result_held", 64'(if3.result), 64'd0);
            tick();
        end
        if3.alu_result = 32'd4;
        if3.alu_flags  = 4'd4;
        chk("c3_result", 64'(if3.result), 64'd3);
        chk("c3_flags", 64'(if3.flags), 64'd3);
        chk("c3_alu_a_idle", 64'(if3.alu_a), 64'd0);
        chk("c3_done_early", 64'(if3.done), 64'd0);
        tick();
        chk("c3_done", 64'(if3.done), 64'd1);
        chk("c3_done_id", 64'(if3.done_id), 64'd0);
        chk("c3_result_hold", 64'(if3.result), 64'd3);
        tick();
        chk("c3_done_once", 64'(if3.done), 64'd0);

        // EXEC_CYCLES=4: reset in the 2nd EXEC cycle aborts the operation.
        rst4 = 1'b0;
        tick();
        if4.req0 = 1'b1;
        if4.op0  = 3'd6;
        if4.a0   = 32'hDEAD_BEEF;
        if4.b0   = 32'd1;
        if4.alu_result = 32'hFFFF_FFFF;
        if4.alu_flags  = 4'hF;
        tick();
        chk("c4_gnt", 64'(if4.gnt), 64'd1);
        chk("c4_alu_a", 64'(if4.alu_a), 64'hDEAD_BEEF);
        if4.req0 = 1'b0;
        tick();
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        chk("c4_gnt_rst", 64'(if4.gnt), 64'd0);
        chk("c4_done_rst", 64'(if4.done), 64'd0);
        chk("c4_result_rst", 64'(if4.result), 64'd0);
        chk("c4_flags_rst", 64'(if4.flags), 64'd0);
        chk("c4_alu_a_rst", 64'(if4.alu_a), 64'd0);
        d4 = 0;
        repeat (10) begin
            tick();
            if (if4.done) d4++;
        end
        chk("c4_no_done", 64'(d4), 64'd0);
        chk("c4_result_after", 64'(if4.result), 64'd0);
        if4.req1 = 1'b1;
        if4.a1   = 32'h0000_0042;
        tick();
        chk("c4_regrant", 64'(if4.gnt), 64'd2);
        if4.req1 = 1'b0;
        repeat (7) tick();
        chk("c4_result_new", 64'(if4.result), 64'hFFFF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
